// File: rtl/gbc_video_pkg.sv
// Shared types and constants for the CGB video subsystem: VRAM DMA state encoding,
// HDMA register offsets within FF51-FF55 and the fixed DMA block size.
package gbc_video_pkg;

    localparam int BLOCK_BYTES = 16;

    typedef enum logic [2:0] {
        IDLE,
        HWAIT,
        RD,
        RDATA,
        WR,
        BLKEND
    } dma_state_t;

    localparam logic [2:0] REG_HDMA1 = 3'd0;
    localparam logic [2:0] REG_HDMA2 = 3'd1;
    localparam logic [2:0] REG_HDMA3 = 3'd2;
    localparam logic [2:0] REG_HDMA4 = 3'd3;
    localparam logic [2:0] REG_HDMA5 = 3'd4;

    // HBlank entry is the PPU leaving pixel transfer (mode 3) straight into mode 0.
    function automatic logic is_hblank_entry(input logic [1:0] mode_prev, input logic [1:0] mode_now);
        return (mode_prev == 2'd3) && (mode_now == 2'd0);
    endfunction

endpackage

// File: rtl/gbc_vram_dma_controller.sv
// CGB VRAM DMA engine (FF51-FF55): copies 16-byte blocks from the system bus into the
// selected VRAM bank, either all at once (GDMA) or one block per HBlank (HDMA).
module gbc_vram_dma_controller
    import gbc_video_pkg::*;
#(
    parameter int LEN_W = 7
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ClkEn,
    input  logic        RegAccess,
    input  logic        RegWrite,
    input  logic [2:0]  RegAddr,
    input  logic [7:0]  RegWData,
    output logic [7:0]  RegRData,
    input  logic [1:0]  Mode,
    input  logic        LcdOn,
    output logic        SrcAccess,
    output logic [15:0] SrcAddress,
    input  logic        SrcReady,
    input  logic        SrcDataReady,
    input  logic [7:0]  SrcData,
    output logic        VramAccess,
    output logic [12:0] VramAddress,
    output logic [7:0]  VramData,
    input  logic        VramReady,
    output logic        DmaActive,
    output logic        CpuStall
);

    localparam int BYTE_W = $clog2(BLOCK_BYTES);
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(BLOCK_BYTES - 1);

    dma_state_t         state_q, state_d;
    logic [15:0]        src_q, src_d;
    logic [12:0]        dst_q, dst_d;
    logic [LEN_W-1:0]   remaining_q, remaining_d;
    logic [BYTE_W-1:0]  byte_q, byte_d;
    logic [7:0]         data_q, data_d;
    logic [1:0]         mode_prev_q, mode_prev_d;
    logic               hdma_q, hdma_d;
    logic               cancel_q, cancel_d;
    logic               kick_q, kick_d;

    logic reg_wr;
    logic ctrl_wr;
    logic cancel_now;
    logic hblank_entry;
    logic block_done;

    assign reg_wr       = ClkEn && RegAccess && RegWrite;
    assign ctrl_wr      = reg_wr && (RegAddr == REG_HDMA5);
    // hdma_q is only ever set while an HDMA transfer is open, so this is the cancel request.
    assign cancel_now   = ctrl_wr && hdma_q && !RegWData[7];
    assign hblank_entry = is_hblank_entry(mode_prev_q, Mode);
    assign block_done   = (remaining_q == '0) || cancel_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (ClkEn) begin
            case (state_q)
                IDLE: begin
                    if (ctrl_wr) state_d = RegWData[7] ? HWAIT : RD;
                end
                HWAIT: begin
                    if (cancel_now || cancel_q)        state_d = IDLE;
                    else if (kick_q || hblank_entry)   state_d = RD;
                end
                RD: begin
                    if (SrcReady) state_d = RDATA;
                end
                RDATA: begin
                    if (SrcDataReady) state_d = WR;
                end
                WR: begin
                    if (VramReady) state_d = (byte_q == LAST_BYTE) ? BLKEND : RD;
                end
                BLKEND: begin
                    if (block_done) state_d = IDLE;
                    else            state_d = hdma_q ? HWAIT : RD;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        SrcAccess   = 1'b0;
        SrcAddress  = '0;
        VramAccess  = 1'b0;
        VramAddress = '0;
        VramData    = '0;
        DmaActive   = 1'b0;
        case (state_q)
            RD: begin
                SrcAccess  = 1'b1;
                SrcAddress = src_q;
                DmaActive  = 1'b1;
            end
            RDATA, BLKEND: begin
                DmaActive = 1'b1;
            end
            WR: begin
                VramAccess  = 1'b1;
                VramAddress = dst_q;
                VramData    = data_q;
                DmaActive   = 1'b1;
            end
            default: ;
        endcase
    end

    assign CpuStall = DmaActive;
    assign RegRData = (RegAddr == REG_HDMA5) ? 8'({(state_q == IDLE), remaining_q}) : 8'hFF;

    always_comb begin
        src_d       = src_q;
        dst_d       = dst_q;
        remaining_d = remaining_q;
        byte_d      = byte_q;
        data_d      = data_q;
        mode_prev_d = mode_prev_q;
        hdma_d      = hdma_q;
        cancel_d    = cancel_q;
        kick_d      = kick_q;
        if (ClkEn) begin
            mode_prev_d = Mode;
            // Address registers double as the running counters, so they only load while idle.
            if (reg_wr && (state_q == IDLE)) begin
                case (RegAddr)
                    REG_HDMA1: src_d[15:8] = RegWData;
                    REG_HDMA2: src_d[7:0]  = {RegWData[7:4], 4'h0};
                    REG_HDMA3: dst_d[12:8] = RegWData[4:0];
                    REG_HDMA4: dst_d[7:0]  = {RegWData[7:4], 4'h0};
                    REG_HDMA5: begin
                        remaining_d = RegWData[LEN_W-1:0];
                        hdma_d      = RegWData[7];
                        cancel_d    = 1'b0;
                        kick_d      = RegWData[7] && !LcdOn;
                        byte_d      = '0;
                    end
                    default: ;
                endcase
            end
            if (cancel_now) cancel_d = 1'b1;
            case (state_q)
                HWAIT: begin
                    if (cancel_now || cancel_q) begin
                        hdma_d   = 1'b0;
                        cancel_d = 1'b0;
                        kick_d   = 1'b0;
                    end else if (kick_q || hblank_entry) begin
                        kick_d = 1'b0;
                    end
                end
                RDATA: begin
                    if (SrcDataReady) data_d = SrcData;
                end
                WR: begin
                    if (VramReady) begin
                        src_d  = src_q + 16'd1;
                        dst_d  = dst_q + 13'd1;
                        byte_d = byte_q + BYTE_W'(1);
                    end
                end
                BLKEND: begin
                    remaining_d = remaining_q - LEN_W'(1);
                    if (block_done) begin
                        hdma_d   = 1'b0;
                        cancel_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            src_q       <= '0;
            dst_q       <= '0;
            remaining_q <= '1;
            byte_q      <= '0;
            data_q      <= '0;
            mode_prev_q <= '0;
            hdma_q      <= 1'b0;
            cancel_q    <= 1'b0;
            kick_q      <= 1'b0;
        end else begin
            src_q       <= src_d;
            dst_q       <= dst_d;
            remaining_q <= remaining_d;
            byte_q      <= byte_d;
            data_q      <= data_d;
            mode_prev_q <= mode_prev_d;
            hdma_q      <= hdma_d;
            cancel_q    <= cancel_d;
            kick_q      <= kick_d;
        end
    end

endmodule
